rs_sched: RTL and testbench

- Single-issue reservation station and scheduler in front of the integer execute pipe.
- Holds renamed uops from allocation until both source physical registers are ready.
- Picks the oldest ready entry each cycle and issues it to the register-read stage, which builds the t_uinstr_iss for EX0.
- Tracks readiness from the integer PRF write port; flushes entirely on a branch mispredict from retire.

---
 rtl/rs_sched_pkg.sv | 59 +++++
 rtl/rs_sched_if.sv | 22 ++
 rtl/rs_sched_age_matrix.sv | 41 ++++
 rtl/rs_sched.sv | 145 ++++++++++++++
 tb/tb_rs_sched.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_sched_pkg.sv
// rs_defs: shared types for the integer reservation station.
//   t_uinstr / t_optype : minimal decoded uop and source operand kind
//   t_rs_alloc_pkt      : allocation payload from rename (RN2)
//   t_rs_iss_pkt        : issue payload towards register read (RS0)
//   t_rs_id             : RS entry index for the default depth
package rs_defs;

    localparam int RS_NUM_ENTRIES = 8;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_REG  = 2'd1,
        OP_IMM  = 2'd2
    } t_optype;

    typedef logic [6:0] t_prf_id;
    typedef logic [5:0] t_rob_id;
    typedef logic [$clog2(RS_NUM_ENTRIES)-1:0] t_rs_id;

    typedef struct packed {
        logic [7:0] opcode;
        t_optype    src1_type;
        t_optype    src2_type;
    } t_uinstr;

    typedef struct packed {
        t_uinstr uinstr;
        t_rob_id robid;
        t_prf_id pdst;
        t_prf_id psrc1;
        t_prf_id psrc2;
        logic    src1_rdy;
        logic    src2_rdy;
    } t_rs_alloc_pkt;

    typedef struct packed {
        t_uinstr uinstr;
        t_rob_id robid;
        t_prf_id pdst;
        t_prf_id psrc1;
        t_prf_id psrc2;
    } t_rs_iss_pkt;

    // Non-register sources never wait on the PRF.
    function automatic logic src_ready(t_optype t, logic rdy);
        return (t != OP_REG) | rdy;
    endfunction

    function automatic t_rs_iss_pkt to_iss(t_rs_alloc_pkt p);
        t_rs_iss_pkt r;
        r.uinstr = p.uinstr;
        r.robid  = p.robid;
        r.pdst   = p.pdst;
        r.psrc1  = p.psrc1;
        r.psrc2  = p.psrc2;
        return r;
    endfunction

endpackage

// File: rtl/rs_sched_if.sv
// rs_sched_if: allocation and issue handshake of the reservation station.
//   master : rename / register-read side (drives alloc, observes issue)
//   slave  : reservation station
interface rs_sched_if;
    import rs_defs::*;

    logic          alloc_valid_rn2;
    t_rs_alloc_pkt alloc_pkt_rn2;
    logic          alloc_ready_rn2;
    logic          iss_valid_rs0;
    t_rs_iss_pkt   iss_pkt_rs0;

    modport master (
        output alloc_valid_rn2, alloc_pkt_rn2,
        input  alloc_ready_rn2, iss_valid_rs0, iss_pkt_rs0
    );

    modport slave (
        input  alloc_valid_rn2, alloc_pkt_rn2,
        output alloc_ready_rn2, iss_valid_rs0, iss_pkt_rs0
    );
endinterface

// File: rtl/rs_sched_age_matrix.sv
// rs_age_matrix: relative-age tracker and oldest-first picker.
//   alloc : one-hot0 entry being written this cycle
//   valid : currently valid entries (before this cycle's updates)
//   req   : entries eligible for selection
//   gnt   : one-hot0 grant of the oldest requester
// age[i][j]=1 means entry i is older than entry j.
module rs_age_matrix #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] alloc,
    input  logic [N-1:0] valid,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    logic [N-1:0][N-1:0] age;

    // A new entry is younger than everything already present. Bits left
    // behind by freed entries are harmless: a reallocated row is cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (alloc[k]) begin
                    age[k] <= '0;
                    for (int i = 0; i < N; i++)
                        if (valid[i]) age[i][k] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt = req;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (req[j] && age[j][i]) gnt[i] = 1'b0;
    end
endmodule

// File: rtl/rs_sched.sv
// rs_sched: single-issue reservation station for the integer pipe.
//   clk, reset      : clock, asynchronous active-high reset
//   stall           : no issue while high
//   br_mispred_rb1  : flush all entries
//   wkup_valid/pdst : PRF write ports, used as source wakeups
//   bus (slave)     : alloc_valid/pkt/ready_rn2, iss_valid/pkt_rs0
//   occupancy       : number of valid entries
// Optional: RS_FASTPATH_EN lets a fully-ready allocating uop issue in the
// same cycle, bypassing the RS, when nothing in the RS is ready.
module rs_sched
    import rs_defs::*;
#(
    parameter int NUM_ENTRIES = RS_NUM_ENTRIES,
    parameter int NUM_WKUP    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          br_mispred_rb1,
    input  logic    [NUM_WKUP-1:0]        wkup_valid,
    input  t_prf_id [NUM_WKUP-1:0]        wkup_pdst,
    rs_sched_if.slave                     bus,
    output logic [$clog2(NUM_ENTRIES):0]  occupancy
);
    localparam int CW = $clog2(NUM_ENTRIES) + 1;
    localparam logic [CW-1:0] FULL = CW'(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0] valid, rdy1, rdy2;
    t_rs_alloc_pkt          ent [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] hit1, hit2, req, gnt, free_sel, alloc_vec, iss_vec;
    logic                   a_hit1, a_hit2, a_rdy1, a_rdy2, found;
    logic                   iss_rs, fast, alloc_we;
    t_rs_alloc_pkt          sel;

    // Freed-by-issue entries only count as free once the edge has passed.
    assign bus.alloc_ready_rn2 = occupancy < FULL;

    always_comb begin
        hit1   = '0;
        hit2   = '0;
        a_hit1 = 1'b0;
        a_hit2 = 1'b0;
        for (int w = 0; w < NUM_WKUP; w++) begin
            if (wkup_valid[w]) begin
                for (int e = 0; e < NUM_ENTRIES; e++) begin
                    if (ent[e].psrc1 == wkup_pdst[w]) hit1[e] = 1'b1;
                    if (ent[e].psrc2 == wkup_pdst[w]) hit2[e] = 1'b1;
                end
                if (bus.alloc_pkt_rn2.psrc1 == wkup_pdst[w]) a_hit1 = 1'b1;
                if (bus.alloc_pkt_rn2.psrc2 == wkup_pdst[w]) a_hit2 = 1'b1;
            end
        end
    end

    // Merge same-cycle wakeups into the allocating uop, or it would miss them.
    assign a_rdy1 = bus.alloc_pkt_rn2.src1_rdy | a_hit1;
    assign a_rdy2 = bus.alloc_pkt_rn2.src2_rdy | a_hit2;

    always_comb begin
        req      = '0;
        free_sel = '0;
        found    = 1'b0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            req[e] = valid[e] & src_ready(ent[e].uinstr.src1_type, rdy1[e])
                              & src_ready(ent[e].uinstr.src2_type, rdy2[e]);
            if (!valid[e] && !found) begin
                free_sel[e] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    rs_age_matrix #(.N(NUM_ENTRIES)) u_age (
        .clk   (clk),
        .reset (reset),
        .alloc (alloc_vec),
        .valid (valid),
        .req   (req),
        .gnt   (gnt)
    );

    assign iss_rs = (|req) & ~stall & ~br_mispred_rb1;

`ifdef RS_FASTPATH_EN
    assign fast = bus.alloc_valid_rn2 & bus.alloc_ready_rn2 & ~br_mispred_rb1 & ~stall & ~(|req)
                & src_ready(bus.alloc_pkt_rn2.uinstr.src1_type, a_rdy1)
                & src_ready(bus.alloc_pkt_rn2.uinstr.src2_type, a_rdy2);
`else
    assign fast = 1'b0;
`endif

    assign alloc_we  = bus.alloc_valid_rn2 & bus.alloc_ready_rn2 & ~br_mispred_rb1 & ~fast;
    assign alloc_vec = alloc_we ? free_sel : '0;
    assign iss_vec   = iss_rs ? gnt : '0;

    always_comb begin
        sel = ent[0];
        for (int e = 0; e < NUM_ENTRIES; e++)
            if (gnt[e]) sel = ent[e];
        bus.iss_valid_rs0 = iss_rs | fast;
        bus.iss_pkt_rs0   = '0;
        if (iss_rs)    bus.iss_pkt_rs0 = to_iss(sel);
        else if (fast) bus.iss_pkt_rs0 = to_iss(bus.alloc_pkt_rn2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid     <= '0;
            rdy1      <= '0;
            rdy2      <= '0;
            occupancy <= '0;
            for (int e = 0; e < NUM_ENTRIES; e++) ent[e] <= '0;
        end else if (br_mispred_rb1) begin
            valid     <= '0;
            occupancy <= '0;
        end else begin
            valid <= (valid & ~iss_vec) | alloc_vec;
            rdy1  <= rdy1 | hit1;
            rdy2  <= rdy2 | hit2;
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (alloc_vec[e]) begin
                    ent[e]  <= bus.alloc_pkt_rn2;
                    rdy1[e] <= a_rdy1;
                    rdy2[e] <= a_rdy2;
                end
            end
            occupancy <= occupancy + CW'(alloc_we) - CW'(iss_rs);
        end
    end

    logic dup_robid;
    always_comb begin
        dup_robid = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            for (int j = i + 1; j < NUM_ENTRIES; j++)
                if (valid[i] && valid[j] && ent[i].robid == ent[j].robid) dup_robid = 1'b1;
    end

    a_sel_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    a_occ_match:  assert property (@(posedge clk) disable iff (reset)
                                   occupancy == CW'($countones(valid)));
    a_robid_uniq: assert property (@(posedge clk) disable iff (reset) !dup_robid);
    a_alloc_full: assert property (@(posedge clk) disable iff (reset)
                                   bus.alloc_valid_rn2 |-> bus.alloc_ready_rn2);
endmodule

// File: tb/tb_rs_sched.sv
module tb_rs_sched;
    import rs_defs::*;

`ifdef RS_FASTPATH_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, stall, br_mispred_rb1;
    logic    [0:0] wkup_valid;
    t_prf_id [0:0] wkup_pdst;
    logic    [3:0] occupancy;
    int            n_cmp = 0;
    int            n_err = 0;

    rs_sched_if bus();

    rs_sched #(.NUM_ENTRIES(8), .NUM_WKUP(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .br_mispred_rb1 (br_mispred_rb1),
        .wkup_valid     (wkup_valid),
        .wkup_pdst      (wkup_pdst),
        .bus            (bus),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    function automatic t_rs_alloc_pkt mk(int r, int s1, bit r1, int s2, bit r2);
        t_rs_alloc_pkt p;
        p                  = '0;
        p.uinstr.opcode    = 8'h11;
        p.uinstr.src1_type = OP_REG;
        p.uinstr.src2_type = OP_REG;
        p.robid            = t_rob_id'(r);
        p.pdst             = t_prf_id'(r + 64);
        p.psrc1            = t_prf_id'(s1);
        p.psrc2            = t_prf_id'(s2);
        p.src1_rdy         = r1;
        p.src2_rdy         = r2;
        return p;
    endfunction

    task automatic idle();
        bus.alloc_valid_rn2 = 1'b0;
        bus.alloc_pkt_rn2   = '0;
        stall               = 1'b0;
        br_mispred_rb1      = 1'b0;
        wkup_valid          = '0;
        wkup_pdst           = '0;
    endtask

    task automatic alloc(t_rs_alloc_pkt p);
        bus.alloc_valid_rn2 = 1'b1;
        bus.alloc_pkt_rn2   = p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_iss(string nm, int c, bit ev, int er);
        n_cmp++;
        if (bus.iss_valid_rs0 !== ev) begin
            n_err++;
            $display("FAIL %s c%0d iss_valid: got %b exp %b", nm, c, bus.iss_valid_rs0, ev);
        end
        if (ev) begin
            n_cmp++;
            if (bus.iss_pkt_rs0.robid !== t_rob_id'(er)) begin
                n_err++;
                $display("FAIL %s c%0d robid: got %0d exp %0d", nm, c, bus.iss_pkt_rs0.robid, er);
            end
        end
    endtask

    task automatic chk_occ(string nm, int exp);
        n_cmp++;
        if (occupancy !== 4'(exp)) begin
            n_err++;
            $display("FAIL %s occupancy: got %0d exp %0d", nm, occupancy, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        step();
        step();
        chk_occ("reset", 0);
        n_cmp++;
        if (bus.alloc_ready_rn2 !== 1'b1) begin
            n_err++;
            $display("FAIL reset alloc_ready: got %b exp 1", bus.alloc_ready_rn2);
        end
        n_cmp++;
        if (bus.iss_valid_rs0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset iss_valid: got %b exp 0", bus.iss_valid_rs0);
        end
        n_cmp++;
        if (bus.iss_pkt_rs0 !== t_rs_iss_pkt'('0)) begin
            n_err++;
            $display("FAIL reset iss_pkt: got %h exp 0", bus.iss_pkt_rs0);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        for (int c = 0; c < 4; c++) begin
            idle();
            if (c < 3) alloc(mk(c + 1, 1, 1'b1, 2, 1'b1));
            #1;
            chk_iss("basic", c, FP ? (c < 3) : (c > 0), FP ? c + 1 : c);
            step();
        end
        idle();
        #1;
        chk_occ("basic_end", 0);
    endtask

    task automatic test_wakeup();
        bit ev[5];
        int er[5];
        ev = '{1'b0, FP, !FP, 1'b0, 1'b1};
        er = '{0, 6, 6, 0, 5};
        for (int c = 0; c < 5; c++) begin
            idle();
            if (c == 0) alloc(mk(5, 8'h10, 1'b0, 3, 1'b1));
            if (c == 1) alloc(mk(6, 4, 1'b1, 5, 1'b1));
            if (c == 3) begin
                wkup_valid = 1'b1;
                wkup_pdst  = 7'h10;
            end
            #1;
            chk_iss("wakeup", c, ev[c], er[c]);
            step();
        end
        idle();
        #1;
        chk_occ("wakeup_end", 0);
    endtask

    task automatic test_full();
        for (int c = 0; c < 8; c++) begin
            idle();
            alloc(mk(10 + c, 8'h40 + c, 1'b0, 1, 1'b1));
            #1;
            chk_iss("full_fill", c, 1'b0, 0);
            step();
        end
        idle();
        #1;
        chk_occ("full", 8);
        for (int k = 0; k < 9; k++) begin
            idle();
            if (k < 8) begin
                wkup_valid = 1'b1;
                wkup_pdst  = t_prf_id'(8'h40 + k);
            end
            #1;
            chk_iss("full_drain", k, k >= 1, 9 + k);
            n_cmp++;
            if (bus.alloc_ready_rn2 !== (k >= 2)) begin
                n_err++;
                $display("FAIL full_drain k%0d alloc_ready: got %b exp %b", k, bus.alloc_ready_rn2, k >= 2);
            end
            step();
        end
        idle();
        #1;
        chk_occ("full_end", 0);
    endtask

    task automatic test_stall();
        for (int c = 0; c < 8; c++) begin
            idle();
            stall = (c < 6);
            if (c == 0) alloc(mk(20, 1, 1'b1, 2, 1'b1));
            if (c == 1) alloc(mk(21, 1, 1'b1, 2, 1'b1));
            #1;
            chk_iss("stall", c, c >= 6, c == 6 ? 20 : 21);
            if (c >= 2 && c < 6) chk_occ("stall_hold", 2);
            step();
        end
        idle();
        #1;
        chk_occ("stall_end", 0);
    endtask

    task automatic test_flush();
        for (int c = 0; c < 2; c++) begin
            idle();
            stall = 1'b1;
            alloc(mk(30 + c, 1, 1'b1, 2, 1'b1));
            step();
        end
        idle();
        br_mispred_rb1 = 1'b1;
        alloc(mk(32, 1, 1'b1, 2, 1'b1));
        #1;
        chk_occ("flush_pre", 2);
        chk_iss("flush", 0, 1'b0, 0);
        step();
        for (int c = 1; c < 3; c++) begin
            idle();
            #1;
            chk_iss("flush_after", c, 1'b0, 0);
            chk_occ("flush_after", 0);
            step();
        end
    endtask

    task automatic test_merge();
        idle();
        alloc(mk(40, 5, 1'b1, 8'h22, 1'b0));
        wkup_valid = 1'b1;
        wkup_pdst  = 7'h22;
        #1;
        chk_iss("merge", 0, FP, 40);
        step();
        idle();
        #1;
        chk_iss("merge", 1, !FP, 40);
        step();
        idle();
        #1;
        chk_occ("merge_end", 0);
    endtask

    task automatic test_reset_mid();
        idle();
        alloc(mk(50, 8'h50, 1'b0, 1, 1'b1));
        step();
        idle();
        alloc(mk(51, 8'h51, 1'b0, 1, 1'b1));
        step();
        idle();
        #1;
        chk_occ("rmid_pre", 2);
        #2 reset = 1'b1;
        #1;
        chk_occ("rmid_async", 0);
        n_cmp++;
        if (bus.alloc_ready_rn2 !== 1'b1) begin
            n_err++;
            $display("FAIL rmid alloc_ready: got %b exp 1", bus.alloc_ready_rn2);
        end
        #1 reset = 1'b0;
        step();
        for (int c = 0; c < 2; c++) begin
            idle();
            wkup_valid = 1'b1;
            wkup_pdst  = t_prf_id'(8'h50 + c);
            step();
        end
        idle();
        #1;
        chk_iss("rmid_stale", 0, 1'b0, 0);
        chk_occ("rmid_stale", 0);
        alloc(mk(52, 1, 1'b1, 2, 1'b1));
        #1;
        chk_iss("rmid_new", 0, FP, 52);
        step();
        idle();
        #1;
        chk_iss("rmid_new", 1, !FP, 52);
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_full();
        test_stall();
        test_flush();
        test_merge();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
